// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives the instruction memory address from pc and registers
// the returned word toward the control unit. Handles branch redirects, stalls and halts.
module instr_fetch #(
    parameter logic [4:0] HALT_OP = 5'b11010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [7:0]  branch_target,
    input  logic        halted_in,
    output logic [7:0]  imem_addr,
    input  logic [8:0]  imem_data,
    output logic [8:0]  instruction_out,
    output logic        instr_valid,
    output logic [7:0]  pc,
    output logic        done,
    output logic [15:0] dyn_count
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT_WAIT,
        DONE
    } state_t;

    state_t      state;
    logic [8:0]  instr_p1;
    logic        vld_p1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign imem_addr       = pc;
    assign instruction_out = instr_p1;
    assign instr_valid     = vld_p1;

    // Stage p0 -> p1: the word at pc is captured into instr_p1 on issue
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= 8'h00;
            instr_p1  <= 9'h000;
            vld_p1    <= 1'b0;
            done      <= 1'b0;
            dyn_count <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    pc     <= 8'h00;
                    vld_p1 <= 1'b0;
                    done   <= 1'b0;
                    if (start) begin
                        state     <= RUN;
                        dyn_count <= 16'h0000;
                    end
                end
                RUN: begin
                    if (branch_taken) begin
                        // The word currently on imem_data is wrong-path: squash it
                        pc       <= branch_target;
                        instr_p1 <= 9'h000;
                        vld_p1   <= 1'b0;
                    end else if (!stall) begin
                        instr_p1  <= imem_data;
                        vld_p1    <= 1'b1;
                        pc        <= pc + 8'd1;
                        dyn_count <= sat_inc16(dyn_count);
                        if (imem_data[8:4] == HALT_OP) begin
                            state <= HALT_WAIT;
                        end
                    end
                end
                HALT_WAIT: begin
                    if (branch_taken) begin
                        // Halt turned out to be wrong-path; resume at the target
                        state    <= RUN;
                        pc       <= branch_target;
                        instr_p1 <= 9'h000;
                        vld_p1   <= 1'b0;
                    end else if (!stall) begin
                        vld_p1 <= 1'b0;
                        if (halted_in) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    vld_p1 <= 1'b0;
                    done   <= 1'b1;
                    if (start) begin
                        state     <= RUN;
                        pc        <= 8'h00;
                        dyn_count <= 16'h0000;
                        done      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port start  in  1  single-cycle pulse that begins program execution.
REQ-004 SHALL have port stall  in  1  hold-off from downstream; freezes fetch state and outputs.
REQ-005 SHALL have port branch_taken  in  1  resolved taken branch/jump from execute.
REQ-006 SHALL have port branch_target  in  8  absolute instruction address for a taken branch.
REQ-007 SHALL have port halted_in  in  1  halt acknowledge from the control unit.
REQ-008 SHALL have port imem_addr  out  8  instruction memory read address.
REQ-009 SHALL have port imem_data  in  9  instruction word, combinationally valid for imem_addr in the same cycle.
REQ-010 SHALL have port instruction_out  out  9  registered instruction word to the control unit.
REQ-011 SHALL have port instr_valid  out  1  instruction_out is a real instruction (0 = bubble).
REQ-012 SHALL have port pc  out  8  address of the next word to fetch.
REQ-013 SHALL have port done  out  1  program has halted.
REQ-014 SHALL have port dyn_count  out  16  count of valid instructions issued.
REQ-015 SHALL have parameter HALT_OP, default 5'b11010, meaning opcode field [8:4] of halt.

Function
REQ-016 SHALL drive imem_addr = pc combinationally.
REQ-017 SHALL implement states IDLE, RUN, HALT_WAIT, DONE.
REQ-018 SHALL, in IDLE, hold pc=0, instr_valid=0, done=0; start=1 -> RUN next cycle, pc=0, dyn_count=0.
REQ-019 SHALL, in RUN with stall=0 and branch_taken=0: instruction_out<=imem_data, instr_valid<=1, pc<=pc+1, dyn_count<=dyn_count+1 (one-cycle issue latency).
REQ-020 SHALL, in RUN with branch_taken=1: pc<=branch_target, instruction_out<=9'h000, instr_valid<=0 (one bubble; wrong-path word squashed, not counted).
REQ-021 SHALL give priority reset > branch_taken > stall > normal issue; branch_taken overrides stall.
REQ-022 SHALL, with stall=1 and branch_taken=0, hold pc, instruction_out, instr_valid, dyn_count and state unchanged.
REQ-023 SHALL, when issuing a word with imem_data[8:4]==HALT_OP, issue it normally (valid, counted), advance pc, and enter HALT_WAIT.
REQ-024 SHALL, in HALT_WAIT, stop fetching: pc held, instr_valid<=0 each cycle.
REQ-025 SHALL, in HALT_WAIT with branch_taken=1 (halt was wrong-path), apply REQ-020 and return to RUN.
REQ-026 SHALL, in HALT_WAIT with halted_in=1 and branch_taken=0, enter DONE.
REQ-027 SHALL, in DONE, assert done=1, instr_valid=0, hold pc and dyn_count; start=1 -> RUN at pc=0, dyn_count=0, done=0.
REQ-028 SHALL ignore start in RUN and HALT_WAIT.
REQ-029 SHALL wrap pc 8'hFF+1 -> 8'h00.
REQ-030 SHALL saturate dyn_count at 16'hFFFF.
REQ-031 SHALL treat halted_in outside HALT_WAIT as don't-care.

Reset
REQ-032 SHALL, on reset=1 at a clock edge in any state: state=IDLE, pc=0, instruction_out=9'h000, instr_valid=0, done=0, dyn_count=0.
REQ-033 SHALL let reset mid-RUN or mid-stall abandon in-flight issue; no instruction is issued in the reset cycle.

Verification
REQ-034 SHALL cover straight-line: ROM 0..3 = add,sub,mv,halt; start -> valid words at cycles 1..4, pc 1..4, HALT_WAIT; halted_in -> done=1, dyn_count=4.
REQ-035 SHALL cover taken branch: branch_taken=1, target=8'h20 while pc=5 -> next instr_valid=0, pc=8'h20; following cycle issues ROM[0x20].
REQ-036 SHALL cover stall 3 cycles mid-RUN -> pc, instruction_out, dyn_count frozen; branch_taken during stall still redirects.
REQ-037 SHALL cover wrong-path halt: halt issued, then branch_taken=1, target=8'h10 in HALT_WAIT -> RUN, pc=8'h10, done stays 0.
REQ-038 SHALL cover pc wrap: ROM filled with non-halt words, run 256 issues -> pc returns to 0, dyn_count=256.
REQ-039 SHALL cover reset mid-RUN at pc=7 -> next cycle IDLE, pc=0, valid=0, done=0; restart via start works.
